// File: rtl/host_stream_loader.sv
// host_stream_loader: host word-stream ingress for the TPU top level.
// Decodes WRITE/START command headers, streams WRITE payloads into the
// unified memory through a registered write port and issues start pulses.
module host_stream_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] host_data,
    input  logic                  host_valid,
    input  logic                  host_last,
    output logic                  host_ready,
    input  logic                  tpu_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  tpu_start,
    output logic                  load_done,
    output logic                  err,
    output logic                  err_sticky
);

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_START = 2'b10;

    // DROP discards an overrunning payload until the host closes the command.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        DROP  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_m1_q;
    logic [ADDR_WIDTH-1:0] count_q;

    logic [1:0]            hdr_op;
    logic [ADDR_WIDTH-1:0] hdr_base;
    logic [ADDR_WIDTH-1:0] hdr_len_m1;

    logic beat;
    logic final_word;
    logic hdr_load;
    logic wr_nxt;
    logic start_nxt;
    logic done_nxt;
    logic err_nxt;

    // Header field views; only meaningful when a header is being accepted.
    assign hdr_op     = host_data[DATA_WIDTH-1 -: 2];
    assign hdr_base   = host_data[ADDR_WIDTH-1:0];
    assign hdr_len_m1 = host_data[8 +: ADDR_WIDTH];

    assign final_word = (count_q == len_m1_q);
    assign beat       = host_valid && host_ready;

    // Ready depends only on state, busy and reset so the host sees it early.
    always_comb begin
        host_ready = 1'b0;
        if (reset) begin
            unique case (state)
                IDLE:    host_ready = !tpu_busy;
                DATA:    host_ready = 1'b1;
                DROP:    host_ready = 1'b1;
                default: host_ready = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and one-cycle-ahead values of the registered outputs.
    always_comb begin
        state_nxt = state;
        hdr_load  = 1'b0;
        wr_nxt    = 1'b0;
        start_nxt = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (beat) begin
                    if (hdr_op == OP_WRITE && !host_last) begin
                        hdr_load  = 1'b1;
                        state_nxt = DATA;
                    end else if (hdr_op == OP_START && host_last) begin
                        start_nxt = 1'b1;
                    end else begin
                        // Bad opcode or wrong framing: report and drop the word.
                        err_nxt = 1'b1;
                    end
                end
            end
            DATA: begin
                if (beat) begin
                    wr_nxt = 1'b1;
                    if (final_word) begin
                        if (host_last) begin
                            done_nxt  = 1'b1;
                            state_nxt = FLUSH;
                        end else begin
                            // Host sent more than the header promised.
                            err_nxt   = 1'b1;
                            state_nxt = DROP;
                        end
                    end else if (host_last) begin
                        // Host closed the command early; the rest is abandoned.
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            DROP: begin
                if (beat && host_last) state_nxt = IDLE;
            end
            FLUSH: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command context: base, length and running word count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            base_q   <= '0;
            len_m1_q <= '0;
            count_q  <= '0;
        end else if (hdr_load) begin
            base_q   <= hdr_base;
            len_m1_q <= hdr_len_m1;
            count_q  <= '0;
        end else if (wr_nxt) begin
            count_q  <= count_q + 1'b1;
        end
    end

    // Registered memory write port; address wraps naturally at ADDR_WIDTH bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_nxt;
            if (wr_nxt) begin
                mem_addr  <= base_q + count_q;
                mem_wdata <= host_data;
            end
        end
    end

    // Registered status pulses; load_done lines up with the final write.
    always_ff @(posedge clk) begin
        if (!reset) begin
            tpu_start  <= 1'b0;
            load_done  <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            tpu_start  <= start_nxt;
            load_done  <= done_nxt;
            err        <= err_nxt;
            err_sticky <= err_sticky | err_nxt;
        end
    end

endmodule
